uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter among `NUM_REQ` byte-stream requesters using round-robin arbitration. Sits between client logic (debug consoles, status reporters) and the UART TX block. It captures one byte from the winning requester into a holding register and presents it on the transmitter's valid/ready input. An optional message-lock mode keeps the grant on one requester until it marks the last byte of a message.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥1, not necessarily a power of two
- `WORD_WIDTH`, 8: byte width; must match the UART TX `WORD_WIDTH`
- `clock`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `req_valid`  in  NUM_REQ  per-requester byte valid
- `req_data`  in  NUM_REQ*WORD_WIDTH  requester i occupies bits [i*WORD_WIDTH +: WORD_WIDTH]
- `req_last`  in  NUM_REQ  byte is the last of a message; used only with lock enabled
- `req_ready`  out  NUM_REQ  one-hot; byte accepted where `req_valid[i] && req_ready[i]`
- `uart_valid`  out  1  drives UART TX `tx_data_valid`
- `uart_data`  out  WORD_WIDTH  drives UART TX `tx_data_in`
- `uart_ready`  in  1  from UART TX `tx_ready`, high while the transmitter is idle
- `grant_id`  out  $clog2(NUM_REQ) (min 1)  index of the last captured requester
- `busy`  out  1  high when the FSM is not in ARB, or when a lock is held

## Operation
- FSM states: ARB, SEND. Reset state is ARB.
- **ARB state**
  - Eligible set = `req_valid`, masked to the lock owner when a lock is held.
  - Winner = first eligible index at or after `rr_ptr`, searching upward with wrap from NUM_REQ-1 to 0.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On capture: `hold_data <= data`, `grant_id <= winner`, go to SEND.
  - If nothing is eligible, stay in ARB and keep all `req_ready` low.
- **SEND state**
  - `uart_valid = 1` and `uart_data = hold_data`. All `req_ready` are low.
  - When `uart_ready = 1`, the byte is handed over. Go to ARB next cycle.
- **`rr_ptr` update**
  - Without a lock held: on capture, `rr_ptr <= winner+1`, wrapping to 0 after NUM_REQ-1.
  - While a lock is held: `rr_ptr` is frozen. It updates only on capture of the `last` byte.
- A requester dropping `req_valid` has no effect on a byte already captured.
- With a lock held and the owner idle, the arbiter waits indefinitely. There is no timeout.
- NUM_REQ=1 degenerates to a pass-through with one cycle of holding latency.

## Timing
- **Reset values:** `req_ready=0`, `uart_valid=0`, `uart_data=0`, `grant_id=0`, `busy=0`, `rr_ptr=0`, lock cleared.
  - Reset asserted mid-SEND drops `uart_valid` immediately; the held byte is discarded.
- **Latency:** byte accepted in cycle N, then `uart_valid` is high from N+1.
  - If `uart_ready` is high at N+1, the UART latches the byte at N+1.
  - The arbiter is back in ARB at N+2 and can accept the next byte at N+2.
- `uart_valid` is never asserted in the same cycle as any `req_ready`.
- `uart_ready` is sampled only in SEND. A low `uart_ready` (UART mid-frame) holds SEND indefinitely with `uart_data` stable.
- **Simultaneous requests:** exactly one grant per capture. No requester waits more than NUM_REQ-1 captures, except behind a lock.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - Capturing a byte with `req_last=0` sets the lock, and the owner becomes `winner`.
  - Capturing a byte with `req_last=1` clears the lock and advances `rr_ptr`.
  - `busy` stays high while the lock is held.
- Undefined:
  - `req_last` is ignored and no lock state exists.
  - Arbitration is per byte, so multi-byte messages from different requesters may interleave.

## Structure
- Shared package `uart_pkg`: `arb_state_t` enum (ARB, SEND) and the helper constant `REQ_IDX_W = (NUM_REQ>1)?$clog2(NUM_REQ):1` as a function.
- One sub-module, `rr_pick`: combinational; inputs are the eligible mask and `rr_ptr`; outputs are a one-hot grant, a binary index and `any`. The FSM, holding register and lock logic stay in `uart_tx_arbiter`.

## Test plan
- **Reset:** assert `rst_n=0` mid-SEND with `hold_data=8'hA5` → `uart_valid` falls without a clock edge; after release, all outputs are 0 and `rr_ptr=0`.
- **Single requester:** req 2 sends 8'h41, with `uart_ready` high → `req_ready=4'b0100` at cycle N, `uart_valid`/`uart_data=8'h41` at N+1, `grant_id=2`, ARB at N+2.
- **Round-robin:** all four requesters continuously valid with a UART model (ready low for 10 cycles per byte) → grant order 0,1,2,3,0,1; no requester is skipped.
- **Backpressure:** hold `uart_ready=0` for 50 cycles in SEND → `uart_data` stays stable, all `req_ready` stay 0, and the handover occurs on the first cycle `uart_ready=1`.
- **Lock (with `UART_ARB_LOCK_EN`):** req 1 sends 3 bytes (last on the third) while req 0 and req 3 are valid → grants 1,1,1 then 3,0; `busy` is high throughout the lock.
- **No lock (without the macro):** same stimulus → grants interleave 1,3,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        SEND = 1'b1
    } arb_state_t;

    // Index width for a requester count; a single requester still gets one bit.
    function automatic int unsigned req_idx_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [NUM_REQ-1:0] upper;

    always_comb begin
        upper = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            upper[j] = eligible[j] && (IDX_W'(j) >= ptr);
        end
    end

    // Lowest eligible index is the wrap fallback; lowest index at/above ptr overrides it.
    always_comb begin
        idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                idx = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (upper[j]) begin
                idx = IDX_W'(j);
            end
        end
        any   = |eligible;
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to hold the grant on one requester until its last byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                            clock,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            uart_valid,
    output logic [WORD_WIDTH-1:0]           uart_data,
    input  logic                            uart_ready,
    output logic [req_idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                            busy
);

    localparam int unsigned REQ_IDX_W = req_idx_w(NUM_REQ);

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic [REQ_IDX_W-1:0]   rr_ptr_q;
    logic [WORD_WIDTH-1:0]  hold_data_q;
    logic [REQ_IDX_W-1:0]   grant_id_q;

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [REQ_IDX_W-1:0]   pick_idx;
    logic                   pick_any;
    logic                   capture;
    logic                   ptr_adv;
    logic                   lock_busy;
    logic [WORD_WIDTH-1:0]  sel_data;
    logic [REQ_IDX_W-1:0]   next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // Data mux driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_data = sel_data | req_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign next_ptr = (pick_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + REQ_IDX_W'(1);

`ifdef UART_ARB_LOCK_EN
    logic                   lock_held_q;
    logic [REQ_IDX_W-1:0]   lock_owner_q;
    logic                   sel_last;

    assign sel_last  = |(req_last & pick_grant);
    assign eligible  = lock_held_q ? (req_valid & (NUM_REQ'(1) << lock_owner_q)) : req_valid;
    // Pointer stays frozen while a message is in progress.
    assign ptr_adv   = capture && (!lock_held_q || sel_last);
    assign lock_busy = lock_held_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lock_held_q  <= 1'b0;
            lock_owner_q <= '0;
        end else if (capture) begin
            lock_held_q  <= !sel_last;
            lock_owner_q <= pick_idx;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign eligible    = req_valid;
    assign ptr_adv     = capture;
    assign lock_busy   = 1'b0;
`endif

    // Next-state and grant decode.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        capture   = 1'b0;
        unique case (state_q)
            ARB: begin
                if (pick_any) begin
                    capture   = 1'b1;
                    req_ready = pick_grant;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (uart_ready) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            hold_data_q <= '0;
            grant_id_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_data_q <= sel_data;
                grant_id_q  <= pick_idx;
            end
            if (ptr_adv) begin
                rr_ptr_q <= next_ptr;
            end
        end
    end

    assign uart_valid = (state_q == SEND);
    assign uart_data  = uart_valid ? hold_data_q : '0;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != ARB) || lock_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed byte streams, UART ready model, order checks.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clock = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           uart_valid;
    logic [W-1:0]   uart_data;
    logic           uart_ready = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W:0]   src_q[N][$];
    logic [N-1:0] acc = '0;
    int vectors = 0;
    int miscompares = 0;
    int handovers = 0;
    int uart_mode = 0;
    int uart_gap = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .WORD_WIDTH (W)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int id, input logic [W-1:0] d, input logic last);
        src_q[id].push_back({last, d});
    endtask

    task automatic expect_byte(input int id, input logic [W-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    // Output monitor: acceptance capture, protocol checks and scoreboard pop.
    always @(negedge clock) begin
        exp_t e;
        if (!rst_n) begin
            acc = '0;
        end else begin
            acc = req_valid & req_ready;
            if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
            if (uart_valid) check("valid_excl_ready", 32'(req_ready), 0);
            if (uart_valid && uart_ready) begin
                handovers++;
                if (uart_mode == 1) uart_gap = 10;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got id %0d data 0x%0h, required none", grant_id, uart_data);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_id", 32'(grant_id), e.id);
                    check("uart_data", 32'(uart_data), 32'(e.data));
                end
            end
        end
    end

    // Requester sources and UART ready model, updated just after each rising edge.
    initial begin
        logic [W:0] f;
        forever begin
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                f = (src_q[i].size() > 0) ? src_q[i][0] : '0;
                req_valid[i]       = src_q[i].size() > 0;
                req_data[i*W +: W] = f[W-1:0];
                req_last[i]        = f[W];
            end
            acc = '0;
            case (uart_mode)
                0: uart_ready = 1'b1;
                1: begin
                    if (uart_gap > 0) begin
                        uart_gap--;
                        uart_ready = 1'b0;
                    end else begin
                        uart_ready = 1'b1;
                    end
                end
                default: uart_ready = 1'b0;
            endcase
        end
    end

    initial begin
        int  h;
        bit  seen;

        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_uart_valid", 32'(uart_valid), 0);
        check("rst_uart_data", 32'(uart_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Round robin from pointer 0 with a slow UART.
        uart_mode = 1;
        send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1);
        send(3, 8'h13, 1'b1); send(0, 8'h20, 1'b1); send(1, 8'h21, 1'b1);
        expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
        expect_byte(3, 8'h13); expect_byte(0, 8'h20); expect_byte(1, 8'h21);
        wait_drain(2000);

        // Single requester timing, pointer now 2.
        uart_mode = 0;
        @(negedge clock);
        send(2, 8'h41, 1'b1);
        expect_byte(2, 8'h41);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = (req_ready != '0);
        end
        check("single_req_ready", 32'(req_ready), 32'h4);
        @(negedge clock);
        check("single_uart_valid", 32'(uart_valid), 1);
        check("single_uart_data", 32'(uart_data), 32'h41);
        check("single_grant_id", 32'(grant_id), 2);
        @(negedge clock);
        check("single_back_arb", 32'(uart_valid), 0);
        check("single_busy_idle", 32'(busy), 0);
        wait_drain(50);

        // Backpressure: UART held not-ready for 50 cycles.
        uart_mode = 2;
        send(0, 8'h5A, 1'b1); send(1, 8'h66, 1'b1);
        expect_byte(0, 8'h5A); expect_byte(1, 8'h66);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = uart_valid;
        end
        check("bp_enter_send", 32'(uart_valid), 1);
        repeat (50) begin
            check("bp_data_stable", 32'(uart_data), 32'h5A);
            check("bp_ready_low", 32'(req_ready), 0);
            @(negedge clock);
        end
        h = handovers;
        uart_mode = 0;
        @(negedge clock);
        #1;
        check("bp_first_ready_handover", handovers, h + 1);
        wait_drain(50);

        // Move pointer to 1, then a 3-byte message from requester 1 against 0 and 3.
        send(0, 8'h30, 1'b1);
        expect_byte(0, 8'h30);
        wait_drain(50);
        send(1, 8'hB1, 1'b0); send(1, 8'hB2, 1'b0); send(1, 8'hB3, 1'b1);
        send(0, 8'hC0, 1'b1); send(3, 8'hD3, 1'b1);
`ifdef UART_ARB_LOCK_EN
        expect_byte(1, 8'hB1); expect_byte(1, 8'hB2); expect_byte(1, 8'hB3);
        expect_byte(3, 8'hD3); expect_byte(0, 8'hC0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = req_ready[1];
        end
        check("lock_first_grant", 32'(req_ready), 32'h2);
        repeat (5) begin
            @(negedge clock);
            check("lock_busy", 32'(busy), 1);
        end
`else
        expect_byte(1, 8'hB1); expect_byte(3, 8'hD3); expect_byte(0, 8'hC0);
        expect_byte(1, 8'hB2); expect_byte(1, 8'hB3);
`endif
        wait_drain(200);

        // Reset during SEND discards the held byte and rewinds the pointer.
        uart_mode = 2;
        send(2, 8'hA5, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = uart_valid;
        end
        check("rst_mid_send_data", 32'(uart_data), 32'hA5);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        #1;
        check("rst_async_valid", 32'(uart_valid), 0);
        check("rst_async_busy", 32'(busy), 0);
        @(negedge clock);
        @(negedge clock);
        uart_mode = 0;
        rst_n = 1'b1;
        check("post_rst_uart_data", 32'(uart_data), 0);
        check("post_rst_grant_id", 32'(grant_id), 0);
        check("post_rst_req_ready", 32'(req_ready), 0);
        send(3, 8'hE3, 1'b1); send(1, 8'hE1, 1'b1);
        expect_byte(1, 8'hE1); expect_byte(3, 8'hE3);
        wait_drain(50);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
